// File: rtl/fir_tap_loader_if.sv
// Coefficient-fetch handshake and tap-write bus between the coefficient store,
// the tap loader and the FIR filter.
interface fir_tap_loader_if #(
  parameter int ADDR_W = 5,
  parameter int COEF_W = 16
);
  logic              coef_rd_req;
  logic [ADDR_W-1:0] coef_rd_addr;
  logic              coef_vld;
  logic [COEF_W-1:0] coef_data;
  logic              tap_wr_en;
  logic [ADDR_W-1:0] tap_wr_addr;
  logic [COEF_W-1:0] tap_wr_data;

  modport master (
    output coef_rd_req, coef_rd_addr, tap_wr_en, tap_wr_addr, tap_wr_data,
    input  coef_vld, coef_data
  );

  modport slave (
    input  coef_rd_req, coef_rd_addr, tap_wr_en, tap_wr_addr, tap_wr_data,
    output coef_vld, coef_data
  );
endinterface

// File: rtl/fir_tap_loader.sv
// Loads FIR tap coefficients from a coefficient store, flushes the delay line
// with zero samples, then releases the filter into normal run.
module fir_tap_loader #(
  parameter int NUM_TAPS  = 32,
  parameter int ADDR_W    = 5,
  parameter int COEF_W    = 16,
  parameter int TIMEOUT   = 255,
  parameter bit AUTO_LOAD = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_start,
  input  logic             i_sample_stb,
  fir_tap_loader_if.master bus,
  output logic             o_fir_en,
  output logic             o_fir_zero,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int FLUSH_W = $clog2(NUM_TAPS + 1);
  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_TAPS - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic               armed_r;
  logic               start_s;
  logic [ADDR_W-1:0]  index_r, index_s;
  logic [WAIT_W-1:0]  wait_r, wait_s;
  logic [FLUSH_W-1:0] flush_r, flush_s;

  logic              req_s, wr_en_s, fir_en_s, fir_zero_s, busy_s, done_s, err_s;
  logic [ADDR_W-1:0] rd_addr_s, wr_addr_s;
  logic [COEF_W-1:0] wr_data_s;

  // armed_r is low only on the first cycle after reset release: that is the auto-start slot
  assign start_s = i_load_start | (AUTO_LOAD & ~armed_r);

  // State register and load/flush counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      armed_r <= 1'b0;
      index_r <= '0;
      wait_r  <= '0;
      flush_r <= '0;
    end else begin
      state_r <= state_s;
      armed_r <= 1'b1;
      index_r <= index_s;
      wait_r  <= wait_s;
      flush_r <= flush_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_s = state_r;
    index_s = index_r;
    wait_s  = wait_r;
    flush_s = flush_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_s = S_REQ;
          index_s = '0;
          wait_s  = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.coef_vld) begin
          state_s = S_WRITE;
        end else if (wait_r == WAIT_LAST) begin
          state_s = S_ERR;
        end else begin
          wait_s = wait_r + WAIT_W'(1);
        end
      end
      S_WRITE: begin
        if (index_r == LAST_IDX) begin
          state_s = S_FLUSH;
          flush_s = '0;
        end else begin
          state_s = S_REQ;
          index_s = index_r + ADDR_W'(1);
          wait_s  = '0;
        end
      end
      S_FLUSH: begin
        if (i_sample_stb) begin
          if (flush_r == FLUSH_LAST) begin
            state_s = S_RUN;
          end else begin
            flush_s = flush_r + FLUSH_W'(1);
          end
        end else begin
          flush_s = flush_r;
        end
      end
      S_RUN, S_ERR: begin
        if (i_load_start) begin
          state_s = S_REQ;
          index_s = '0;
          wait_s  = '0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so outputs register in step with state_r
  always_comb begin
    req_s      = 1'b0;
    rd_addr_s  = '0;
    wr_en_s    = 1'b0;
    wr_addr_s  = '0;
    wr_data_s  = '0;
    fir_en_s   = 1'b0;
    fir_zero_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_s)
      S_REQ: begin
        req_s     = 1'b1;
        rd_addr_s = index_s;
        busy_s    = 1'b1;
      end
      S_WRITE: begin
        // WRITE is only entered from REQ with vld high, so coef_data is the captured value
        wr_en_s   = 1'b1;
        wr_addr_s = index_s;
        wr_data_s = bus.coef_data;
        busy_s    = 1'b1;
      end
      S_FLUSH: begin
        fir_en_s   = 1'b1;
        fir_zero_s = 1'b1;
        busy_s     = 1'b1;
      end
      S_RUN: begin
        fir_en_s = 1'b1;
        done_s   = (state_r != S_RUN);
      end
      S_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.coef_rd_req  <= 1'b0;
      bus.coef_rd_addr <= '0;
      bus.tap_wr_en    <= 1'b0;
      bus.tap_wr_addr  <= '0;
      bus.tap_wr_data  <= '0;
      o_fir_en         <= 1'b0;
      o_fir_zero       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
    end else begin
      bus.coef_rd_req  <= req_s;
      bus.coef_rd_addr <= rd_addr_s;
      bus.tap_wr_en    <= wr_en_s;
      bus.tap_wr_addr  <= wr_addr_s;
      bus.tap_wr_data  <= wr_data_s;
      o_fir_en         <= fir_en_s;
      o_fir_zero       <= fir_zero_s;
      o_busy           <= busy_s;
      o_done           <= done_s;
      o_err            <= err_s;
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench: a 4-tap loader driven step by step, plus a 32-tap loader
// whose coefficient store answers in the same cycle as the request.
module tb_fir_tap_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst32_n, load_start, sample_stb;
  logic fir_en, fir_zero, busy, done, err;
  logic fir_en32, fir_zero32, busy32, done32, err32;
  logic load_start32, sample_stb32;

  fir_tap_loader_if #(.ADDR_W(2), .COEF_W(16)) bus4 ();
  fir_tap_loader_if #(.ADDR_W(5), .COEF_W(16)) bus32 ();

  fir_tap_loader #(.NUM_TAPS(4), .ADDR_W(2), .COEF_W(16), .TIMEOUT(10), .AUTO_LOAD(1'b1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_sample_stb(sample_stb),
    .bus(bus4), .o_fir_en(fir_en), .o_fir_zero(fir_zero), .o_busy(busy), .o_done(done), .o_err(err)
  );

  fir_tap_loader #(.NUM_TAPS(32), .ADDR_W(5), .COEF_W(16), .TIMEOUT(255), .AUTO_LOAD(1'b1)) dut32 (
    .i_clk(clk), .i_rst_n(rst32_n), .i_load_start(load_start32), .i_sample_stb(sample_stb32),
    .bus(bus32), .o_fir_en(fir_en32), .o_fir_zero(fir_zero32), .o_busy(busy32), .o_done(done32),
    .o_err(err32)
  );

  // Zero-latency coefficient store: data = 0x1000 + index
  assign bus32.coef_vld  = bus32.coef_rd_req;
  assign bus32.coef_data = 16'h1000 + {11'd0, bus32.coef_rd_addr};

  // {req, wr_en, fir_en, fir_zero, busy, done, err}
  logic [6:0] st4, st32;
  assign st4  = {bus4.coef_rd_req, bus4.tap_wr_en, fir_en, fir_zero, busy, done, err};
  assign st32 = {bus32.coef_rd_req, bus32.tap_wr_en, fir_en32, fir_zero32, busy32, done32, err32};

  localparam logic [6:0] ST_ZERO  = 7'b000_0000;
  localparam logic [6:0] ST_REQ   = 7'b100_0100;
  localparam logic [6:0] ST_WRITE = 7'b010_0100;
  localparam logic [6:0] ST_FLUSH = 7'b001_1100;
  localparam logic [6:0] ST_DONE  = 7'b001_0010;
  localparam logic [6:0] ST_RUN   = 7'b001_0000;
  localparam logic [6:0] ST_ERR   = 7'b000_0001;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serve one coefficient on dut4: vld returns one cycle after the request is seen
  task automatic load_tap(input int k, input logic [15:0] d);
    chk("req_state", 32'(st4), 32'(ST_REQ));
    chk("req_addr", 32'(bus4.coef_rd_addr), 32'(k));
    tick();
    chk("req_hold", 32'(st4), 32'(ST_REQ));
    bus4.coef_vld  = 1'b1;
    bus4.coef_data = d;
    tick();
    bus4.coef_vld  = 1'b0;
    bus4.coef_data = 16'hDEAD;
    chk("write_state", 32'(st4), 32'(ST_WRITE));
    chk("write_addr", 32'(bus4.tap_wr_addr), 32'(k));
    chk("write_data", 32'(bus4.tap_wr_data), 32'(d));
    tick();
  endtask

  int nw;
  int last_c;

  initial begin
    rst_n = 1'b0;
    rst32_n = 1'b0;
    load_start = 1'b0;
    sample_stb = 1'b0;
    load_start32 = 1'b0;
    sample_stb32 = 1'b0;
    bus4.coef_vld = 1'b0;
    bus4.coef_data = 16'h0000;
    repeat (2) tick();
    chk("reset_st4", 32'(st4), 32'(ST_ZERO));
    chk("reset_st32", 32'(st32), 32'(ST_ZERO));

    // Auto-load after reset release, vld one cycle after each request
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) load_tap(k, 16'(16'h0101 * (k + 1)));

    // Flush: 4 strobes spaced 5 cycles apart, a load_start in the middle is ignored
    chk("flush_entry", 32'(st4), 32'(ST_FLUSH));
    for (int s = 0; s < 4; s++) begin
      repeat (4) tick();
      chk("flush_wait", 32'(st4), 32'(ST_FLUSH));
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      if (s < 3) begin
        chk("flush_stb", 32'(st4), 32'(ST_FLUSH));
      end else begin
        chk("run_done", 32'(st4), 32'(ST_DONE));
      end
      if (s == 1) begin
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("flush_ignore_start", 32'(st4), 32'(ST_FLUSH));
      end
    end
    tick();
    chk("run_steady", 32'(st4), 32'(ST_RUN));

    // Reload from RUN
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 4; k++) load_tap(k, 16'(16'hA000 + k));
    chk("reflush", 32'(st4), 32'(ST_FLUSH));
    sample_stb = 1'b1;
    repeat (3) tick();
    chk("reflush_3stb", 32'(st4), 32'(ST_FLUSH));
    tick();
    sample_stb = 1'b0;
    chk("rerun_done", 32'(st4), 32'(ST_DONE));

    // Timeout at index 2: 10 REQ cycles then ERR
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_tap(0, 16'h5A5A);
    load_tap(1, 16'hA5A5);
    chk("to_req_addr", 32'(bus4.coef_rd_addr), 32'd2);
    repeat (9) tick();
    chk("to_req_last", 32'(st4), 32'(ST_REQ));
    tick();
    chk("to_err", 32'(st4), 32'(ST_ERR));
    bus4.coef_vld = 1'b1;
    repeat (3) tick();
    bus4.coef_vld = 1'b0;
    chk("err_sticky", 32'(st4), 32'(ST_ERR));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_tap(0, 16'h0F0F);

    // Asynchronous reset at index 1, then auto-restart from address 0
    chk("pre_rst_addr", 32'(bus4.coef_rd_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_st", 32'(st4), 32'(ST_ZERO));
    chk("async_rst_addr", 32'(bus4.coef_rd_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_st", 32'(st4), 32'(ST_REQ));
    chk("restart_addr", 32'(bus4.coef_rd_addr), 32'd0);

    // 32 taps, vld in the request cycle: 2 cycles per tap
    rst32_n = 1'b1;
    tick();
    chk("l32_req0", 32'(st32), 32'(ST_REQ));
    nw = 0;
    last_c = 0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (bus32.tap_wr_en) begin
        chk("l32_wr_addr", 32'(bus32.tap_wr_addr), 32'(nw));
        chk("l32_wr_data", 32'(bus32.tap_wr_data), 32'(16'h1000 + nw));
        nw++;
        last_c = c + 1;
      end
    end
    chk("l32_count", 32'(nw), 32'd32);
    chk("l32_last_cycle", 32'(last_c), 32'd64);
    chk("l32_flush", 32'(st32), 32'(ST_FLUSH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
